// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage in front of the IF/ID pipeline buffer.
//
// This block owns the program counter. It issues word fetches to instruction
// memory over a req/ack handshake and presents each returned instruction on
// out_pc/out_inst with a valid flag.
//
// It also handles two kinds of disturbance:
//   - Downstream stall: an instruction that returns during a stall is parked
//     in a hold register, and no new fetch is issued until it drains.
//   - Branch/jump redirect: a fetch that is still in flight when the redirect
//     arrives is squashed, and the target is fetched once that fetch's ack
//     has been absorbed.
//
// Parameters
//   RESET_PC     PC loaded on reset
//   PC_STEP      increment applied to the PC after each accepted fetch
//                (instruction memory is word-addressed)
//
// Ports
//   clk          clock, all state changes on posedge
//   rst_n        asynchronous active-low reset
//   stall        downstream hold; out_* frozen unless redirected
//   redirect     taken branch/jump, flushes fetch state
//   redirect_pc  target PC, sampled when redirect=1
//   imem_req     fetch request (high whenever the FSM is in REQ)
//   imem_addr    fetch address (the current PC)
//   imem_ack     imem_data valid this cycle; may coincide with imem_req
//   imem_data    fetched instruction word
//   out_pc       PC of the presented instruction (to IF/ID in_pc)
//   out_inst     presented instruction, 0 (NOP) when not valid
//   out_valid    out_pc/out_inst hold a real instruction
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_valid
);

  // REQ : a fetch is outstanding at address pc.
  // HOLD: one fetched instruction is parked while downstream is stalled;
  //       no request is issued until it has been handed over.
  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        squash, squash_nxt;
  logic [31:0] squash_pc, squash_pc_nxt;
  logic [31:0] hold_pc, hold_pc_nxt;
  logic [31:0] hold_inst, hold_inst_nxt;
  logic [31:0] out_pc_nxt;
  logic [31:0] out_inst_nxt;
  logic        out_valid_nxt;

  // The address is the PC itself. The PC only moves on an ack (or when
  // leaving HOLD), so the address stays stable for as long as a request is
  // pending.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  // Next-state and output logic. Everything defaults to "hold", so each
  // branch below lists only what changes.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    squash_nxt    = squash;
    squash_pc_nxt = squash_pc;
    hold_pc_nxt   = hold_pc;
    hold_inst_nxt = hold_inst;
    out_pc_nxt    = out_pc;
    out_inst_nxt  = out_inst;
    out_valid_nxt = out_valid;

    case (state)
      S_REQ: begin
        if (redirect && imem_ack) begin
          // The returning word belongs to the wrong path; the target is
          // requested next cycle. Any earlier pending squash is superseded.
          pc_nxt        = redirect_pc;
          squash_nxt    = 1'b0;
          out_valid_nxt = 1'b0;
          out_inst_nxt  = '0;
        end else if (redirect) begin
          // The request at pc is already visible to memory and must complete
          // before the address may change. Remember the target and discard
          // the data when it arrives. A later redirect overwrites the target.
          squash_nxt    = 1'b1;
          squash_pc_nxt = redirect_pc;
          out_valid_nxt = 1'b0;
          out_inst_nxt  = '0;
        end else if (imem_ack && squash) begin
          // The squashed fetch has completed; start fetching the target.
          pc_nxt     = squash_pc;
          squash_nxt = 1'b0;
          if (!stall) begin
            out_valid_nxt = 1'b0;
            out_inst_nxt  = '0;
          end
        end else if (imem_ack && !stall) begin
          out_pc_nxt    = pc;
          out_inst_nxt  = imem_data;
          out_valid_nxt = 1'b1;
          pc_nxt        = pc + PC_STEP;
        end else if (imem_ack) begin
          // The word arrived but downstream cannot take it: park it, and stop
          // requesting so at most one instruction is ever buffered.
          hold_pc_nxt   = pc;
          hold_inst_nxt = imem_data;
          pc_nxt        = pc + PC_STEP;
          state_nxt     = S_HOLD;
        end else if (!stall) begin
          // Wait state with downstream ready: emit a bubble.
          out_valid_nxt = 1'b0;
          out_inst_nxt  = '0;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          // The parked instruction is on the wrong path. Nothing is in
          // flight, so the target can be requested immediately.
          pc_nxt        = redirect_pc;
          out_valid_nxt = 1'b0;
          out_inst_nxt  = '0;
          state_nxt     = S_REQ;
        end else if (!stall) begin
          out_pc_nxt    = hold_pc;
          out_inst_nxt  = hold_inst;
          out_valid_nxt = 1'b1;
          state_nxt     = S_REQ;
        end
      end

      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // ---- state / output register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      squash    <= 1'b0;
      squash_pc <= '0;
      hold_pc   <= '0;
      hold_inst <= '0;
      out_pc    <= '0;
      out_inst  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      squash    <= squash_nxt;
      squash_pc <= squash_pc_nxt;
      hold_pc   <= hold_pc_nxt;
      hold_inst <= hold_inst_nxt;
      out_pc    <= out_pc_nxt;
      out_inst  <= out_inst_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Self-checking bench for if_fetch_unit. Stimulus is driven 1 time unit after
// each rising edge, and outputs are checked at that same point.
//
// The bench is organised in four parts:
//   1. A vector table: zero-wait memory, stalls, and redirects.
//   2. Hand-written sequences: wait states, squash, a double redirect,
//      reset mid-fetch, and PC wrap.
//   3. A randomized run against a queue-based reference model.
//   4. A single summary line.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_valid;

  if_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Memory model. In directed mode it acks after mem_wait wait cycles and
  // returns addr+0x100. In random mode the ack is a per-cycle coin flip and
  // the data is a hash of the address.
  int   mem_wait = 0;
  bit   mem_rand = 1'b0;
  bit   rnd_ack  = 1'b0;
  int   cnt;

  function automatic logic [31:0] mem_fn(input logic [31:0] a, input bit r);
    return r ? ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000) : (a + 32'h100);
  endfunction

  assign imem_ack  = imem_req & (mem_rand ? rnd_ack : (cnt >= mem_wait));
  assign imem_data = mem_fn(imem_addr, mem_rand);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= 0;
    else if (imem_req && !imem_ack) cnt <= cnt + 1;
    else                             cnt <= 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    rnd_ack     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_pc"},    out_pc,         p);
    chk({tag, "_inst"},  out_inst,       i);
  endtask

  // ---- vector table ----
  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vt[16];

  // ---- reference model: architectural view of the fetch stage ----
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } park_t;

  logic [31:0] m_pc, m_out_pc, m_out_inst;
  logic        m_out_valid;
  logic [31:0] pend[$];    // redirect target waiting for an in-flight ack
  park_t       parked[$];  // instruction fetched during a stall

  function automatic void model_reset();
    m_pc        = 32'h0;
    m_out_pc    = '0;
    m_out_inst  = '0;
    m_out_valid = 1'b0;
    pend.delete();
    parked.delete();
  endfunction

  function automatic void model_bubble();
    m_out_valid = 1'b0;
    m_out_inst  = '0;
  endfunction

  // Advance the model by one clock, using the inputs currently applied.
  function automatic void model_step();
    bit          fetching = (parked.size() == 0);
    bit          ack      = fetching && rnd_ack;
    logic [31:0] data     = mem_fn(m_pc, 1'b1);
    park_t       p;
    if (!fetching) begin
      if (redirect) begin
        parked.delete();
        m_pc = redirect_pc;
        model_bubble();
      end else if (!stall) begin
        p = parked.pop_front();
        m_out_pc    = p.pc;
        m_out_inst  = p.inst;
        m_out_valid = 1'b1;
      end
    end else if (redirect) begin
      if (ack) begin
        pend.delete();
        m_pc = redirect_pc;
      end else begin
        pend.delete();
        pend.push_back(redirect_pc);
      end
      model_bubble();
    end else if (ack && pend.size() != 0) begin
      m_pc = pend.pop_front();
      if (!stall) model_bubble();
    end else if (ack) begin
      if (stall) begin
        p.pc   = m_pc;
        p.inst = data;
        parked.push_back(p);
      end else begin
        m_out_pc    = m_pc;
        m_out_inst  = data;
        m_out_valid = 1'b1;
      end
      m_pc = m_pc + 32'd1;
    end else if (!stall) begin
      model_bubble();
    end
  endfunction

  initial begin
    // Zero-wait memory, data = addr+0x100.
    //        stall redir rpc          req   addr          vld  pc            inst
    vt[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1,   1'b1, 32'h0,   32'h100};
    vt[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h2,   1'b1, 32'h1,   32'h101};
    vt[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h3,   1'b1, 32'h2,   32'h102};
    vt[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h3,   32'h103};
    vt[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h5,   1'b1, 32'h4,   32'h104};
    vt[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h6,   1'b1, 32'h4,   32'h104};
    vt[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h6,   1'b1, 32'h4,   32'h104};
    vt[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h6,   1'b1, 32'h4,   32'h104};
    vt[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h6,   1'b1, 32'h5,   32'h105};
    vt[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h7,   1'b1, 32'h6,   32'h106};
    vt[10] = '{1'b0, 1'b1, 32'h40,  1'b1, 32'h40,  1'b0, 32'h6,   32'h0};
    vt[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h41,  1'b1, 32'h40,  32'h140};
    vt[12] = '{1'b1, 1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 32'h40,  32'h0};
    vt[13] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h81,  1'b0, 32'h40,  32'h0};
    vt[14] = '{1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h40,  32'h0};
    vt[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h201, 1'b1, 32'h200, 32'h300};

    // Reset state
    mem_rand = 1'b0;
    mem_wait = 0;
    do_reset();
    chk_out("rst", 1'b0, 32'h0, 32'h0);
    chk("rst_req",  32'(imem_req), 32'h1);
    chk("rst_addr", imem_addr,     32'h0);

    // Table
    for (int i = 0; i < 16; i++) begin
      stall       = vt[i].stall;
      redirect    = vt[i].redir;
      redirect_pc = vt[i].rpc;
      tick();
      chk($sformatf("vec%0d_req", i),  32'(imem_req), 32'(vt[i].exp_req));
      chk($sformatf("vec%0d_addr", i), imem_addr,     vt[i].exp_addr);
      chk_out($sformatf("vec%0d", i), vt[i].exp_valid, vt[i].exp_pc, vt[i].exp_inst);
    end
    stall    = 1'b0;
    redirect = 1'b0;

    // 2 wait states: address stable 3 cycles, valid pattern 0,0,1
    mem_wait = 2;
    do_reset();
    for (int t = 1; t <= 9; t++) begin
      tick();
      chk($sformatf("w2_valid_%0d", t), 32'(out_valid), 32'((t % 3) == 0));
      chk($sformatf("w2_addr_%0d", t),  imem_addr,      32'(t / 3));
      if ((t % 3) == 0) chk($sformatf("w2_pc_%0d", t), out_pc, 32'(t / 3 - 1));
    end

    // 3 wait states, redirect to 0x80 in the first wait cycle
    mem_wait = 3;
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    chk("sq_valid_1", 32'(out_valid), 32'h0);
    chk("sq_addr_1",  imem_addr,      32'h0);
    tick();
    tick();
    chk("sq_addr_3",  imem_addr,      32'h0);
    tick();  // squashed ack absorbed here
    chk("sq_addr_4",  imem_addr,      32'h80);
    chk("sq_valid_4", 32'(out_valid), 32'h0);
    for (int t = 5; t <= 7; t++) begin
      tick();
      chk($sformatf("sq_valid_%0d", t), 32'(out_valid), 32'h0);
    end
    tick();
    chk_out("sq_tgt", 1'b1, 32'h80, 32'h180);

    // Reset mid-wait: outputs flushed asynchronously, PC back to RESET_PC
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_out("amid", 1'b0, 32'h0, 32'h0);
    chk("amid_addr", imem_addr, 32'h0);
    tick();
    rst_n = 1'b1;

    // Second redirect while squash is pending: last target wins
    redirect    = 1'b1;
    redirect_pc = 32'h10;
    tick();
    redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    chk("dbl_addr",  imem_addr,      32'h20);
    chk("dbl_valid", 32'(out_valid), 32'h0);

    // PC wrap through 0xFFFF_FFFF with zero-wait memory
    mem_wait = 0;
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFE);
    tick();
    chk_out("wrap_a", 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE + 32'h100);
    tick();
    chk_out("wrap_b", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF + 32'h100);
    tick();
    chk_out("wrap_c", 1'b1, 32'h0, 32'h100);
    chk("wrap_addr3", imem_addr, 32'h1);

    // Randomized run against the reference model
    mem_rand = 1'b1;
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      chk("rnd_req",   32'(imem_req),  32'(parked.size() == 0));
      chk("rnd_addr",  imem_addr,      m_pc);
      chk("rnd_valid", 32'(out_valid), 32'(m_out_valid));
      chk("rnd_pc",    out_pc,         m_out_pc);
      chk("rnd_inst",  out_inst,       m_out_inst);
      stall       = (($urandom % 4) == 0);
      redirect    = (($urandom % 12) == 0);
      redirect_pc = (($urandom % 3) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
      rnd_ack     = (($urandom % 3) != 0);
      model_step();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
